redmule_tcdm_splitter: RTL

REDMULE_TCDM_SPLITTER -- requirements
Module: redmule_tcdm_splitter

---
 rtl/redmule_tcdm_splitter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/redmule_tcdm_splitter.sv
// Splits a wide RedMulE memory request into MP independently granted 32-bit TCDM
// requests and reassembles the per-port responses into in-order wide responses.
module redmule_tcdm_splitter #(
  parameter int unsigned MP    = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             up_req_i,
  output logic             up_gnt_o,
  input  logic [AW-1:0]    up_add_i,
  input  logic             up_wen_i,
  input  logic [MP*4-1:0]  up_be_i,
  input  logic [MP*32-1:0] up_data_i,
  output logic             up_r_valid_o,
  output logic [MP*32-1:0] up_r_data_o,
  output logic [MP-1:0]    tcdm_req_o,
  input  logic [MP-1:0]    tcdm_gnt_i,
  output logic [MP*AW-1:0] tcdm_add_o,
  output logic [MP-1:0]    tcdm_wen_o,
  output logic [MP*4-1:0]  tcdm_be_o,
  output logic [MP*32-1:0] tcdm_data_o,
  input  logic [MP-1:0]    tcdm_r_valid_i,
  input  logic [MP*32-1:0] tcdm_r_data_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [MP-1:0] granted_q, granted_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q  [MP][DEPTH];
  logic [31:0]   mem_d  [MP][DEPTH];
  logic [PW-1:0] wptr_q [MP];
  logic [PW-1:0] wptr_d [MP];
  logic [PW-1:0] rptr_q [MP];
  logic [PW-1:0] rptr_d [MP];
  logic [CW-1:0] fcnt_q [MP];
  logic [CW-1:0] fcnt_d [MP];

  logic          active;
  logic          credit_ok;
  logic          pop;
  logic [MP-1:0] fifo_ne;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake, port fan-out and response assembly
  always_comb begin
    active    = rst_ni & ~clear_i;
    credit_ok = (cnt_q < CW'(DEPTH));
    for (int unsigned ii = 0; ii < MP; ii++) begin
      fifo_ne[ii]               = (fcnt_q[ii] != '0);
      tcdm_add_o[ii*AW +: AW]   = up_add_i + AW'(4 * ii);
      tcdm_wen_o[ii]            = up_wen_i;
      tcdm_be_o[ii*4 +: 4]      = up_be_i[ii*4 +: 4];
      tcdm_data_o[ii*32 +: 32]  = up_data_i[ii*32 +: 32];
    end
    tcdm_req_o   = {MP{up_req_i & credit_ok & active}} & ~granted_q;
    up_gnt_o     = up_req_i & credit_ok & active & (&(granted_q | tcdm_gnt_i));
    pop          = active & (&fifo_ne);
    up_r_valid_o = pop;
    for (int unsigned ii = 0; ii < MP; ii++) begin
      up_r_data_o[ii*32 +: 32] = pop ? mem_q[ii][rptr_q[ii]] : 32'h0;
    end
    busy_o = active & ((cnt_q != '0) | (|granted_q));
    err_o  = active & err_q;
  end

  // Next-state: grant tracking, credit counter, per-port response FIFOs
  always_comb begin
    cnt_d     = cnt_q;
    granted_d = granted_q;
    err_d     = err_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fcnt_d    = fcnt_q;

    if (up_gnt_o) begin
      granted_d = '0;
    end else begin
      granted_d = granted_q | (tcdm_req_o & tcdm_gnt_i);
    end

    if (up_gnt_o && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!up_gnt_o && pop) begin
      cnt_d = cnt_q - CW'(1);
    end

    for (int unsigned ii = 0; ii < MP; ii++) begin
      logic full, push;
      full = (fcnt_q[ii] == CW'(DEPTH));
      push = tcdm_r_valid_i[ii] & (~full | pop);
      // A full FIFO can still accept when the same cycle pops it
      if (tcdm_r_valid_i[ii] && full && !pop) begin
        err_d = 1'b1;
      end
      if (push) begin
        mem_d[ii][wptr_q[ii]] = tcdm_r_data_i[ii*32 +: 32];
        wptr_d[ii]            = ptr_inc(wptr_q[ii]);
      end
      if (pop) begin
        rptr_d[ii] = ptr_inc(rptr_q[ii]);
      end
      fcnt_d[ii] = fcnt_q[ii] + CW'(push) - CW'(pop);
    end

    if (clear_i) begin
      cnt_d     = '0;
      granted_d = '0;
      err_d     = 1'b0;
      for (int unsigned ii = 0; ii < MP; ii++) begin
        wptr_d[ii] = '0;
        rptr_d[ii] = '0;
        fcnt_d[ii] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      granted_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned ii = 0; ii < MP; ii++) begin
        wptr_q[ii] <= '0;
        rptr_q[ii] <= '0;
        fcnt_q[ii] <= '0;
        for (int unsigned jj = 0; jj < DEPTH; jj++) begin
          mem_q[ii][jj] <= '0;
        end
      end
    end else begin
      cnt_q     <= cnt_d;
      granted_q <= granted_d;
      err_q     <= err_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      mem_q     <= mem_d;
    end
  end

endmodule
